// File: rtl/fetch_pkg.sv
// Shared types and constants for the bytecode instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_LATCH,
        S_ARG1,
        S_ARG2,
        S_PRESENT,
        S_HALT
    } fetch_state_t;

    localparam int PC_RESET = 0;

    localparam logic [7:0] OP_IRETURN = 8'hac;
    localparam logic [7:0] OP_ARETURN = 8'hb0;
    localparam logic [7:0] OP_RETURN  = 8'hb1;

    function automatic logic is_return(input logic [7:0] op);
        return (op == OP_IRETURN) || (op == OP_ARETURN) || (op == OP_RETURN);
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter with next-PC selection: sequential advance past the
// operands, or a redirect relative to the presented instruction's address.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  jump,
    input  logic [1:0]            argc,
    input  logic [ADDR_WIDTH-1:0] base_pc,
    input  logic [15:0]           jump_offset,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] off_ext;
    logic [ADDR_WIDTH-1:0] next_pc;

    // Offset is signed 16-bit: sign-extend for wide PCs, truncate for narrow.
    if (ADDR_WIDTH > 16) begin : g_sext
        assign off_ext = {{(ADDR_WIDTH-16){jump_offset[15]}}, jump_offset};
    end else begin : g_trunc
        assign off_ext = jump_offset[ADDR_WIDTH-1:0];
    end

    always_comb begin
        next_pc = pc + ADDR_WIDTH'(argc) + ADDR_WIDTH'(1);
        if (jump)
            next_pc = base_pc + off_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= ADDR_WIDTH'(PC_RESET);
        else if (advance)
            pc <= next_pc;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads opcode and 0-2 operand bytes, presents the
// instruction over valid/ready. Optional halt-on-return via FETCH_HALT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            dec_opcode,
    input  logic [1:0]            dec_argc,
    output logic                  ins_valid,
    input  logic                  ins_ready,
    output logic [7:0]            ins_opcode,
    output logic [15:0]           ins_args,
    output logic [ADDR_WIDTH-1:0] ins_pc,
    input  logic                  jump_en,
    input  logic [15:0]           jump_offset,
    output logic                  halted
);

    fetch_state_t          state, next_state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [7:0]            opcode_q;
    logic [1:0]            argc_q;
    logic [7:0]            b1_q;
    logic [1:0]            argc_norm;
    logic                  advance;
    logic                  halt_take;

    assign argc_norm = (dec_argc == 2'b11) ? 2'b10 : dec_argc;
    assign advance   = (state == S_PRESENT) && ins_ready;

`ifdef FETCH_HALT_EN
    assign halt_take = is_return(ins_opcode);
    assign halted    = (state == S_HALT);
`else
    assign halt_take = 1'b0;
    assign halted    = 1'b0;
`endif

    fetch_pc #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (advance),
        .jump        (jump_en && !halt_take),
        .argc        (argc_q),
        .base_pc     (ins_pc),
        .jump_offset (jump_offset),
        .pc          (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_rd     = 1'b0;
        mem_addr   = pc;
        dec_opcode = opcode_q;
        case (state)
            S_IDLE: next_state = S_OP;
            S_OP: begin
                mem_rd     = 1'b1;
                next_state = S_LATCH;
            end
            S_LATCH: begin
                // Decoder sees the opcode the same cycle it arrives from memory.
                dec_opcode = mem_rdata;
                if (argc_norm == 2'd0) begin
                    next_state = S_PRESENT;
                end else begin
                    mem_rd     = 1'b1;
                    mem_addr   = pc + ADDR_WIDTH'(1);
                    next_state = S_ARG1;
                end
            end
            S_ARG1: begin
                if (argc_q == 2'd2) begin
                    mem_rd     = 1'b1;
                    mem_addr   = pc + ADDR_WIDTH'(2);
                    next_state = S_ARG2;
                end else begin
                    next_state = S_PRESENT;
                end
            end
            S_ARG2: next_state = S_PRESENT;
            S_PRESENT: begin
                if (ins_ready)
                    next_state = halt_take ? S_HALT : S_OP;
            end
`ifdef FETCH_HALT_EN
            S_HALT: next_state = S_HALT;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q   <= 8'h00;
            argc_q     <= 2'd0;
            b1_q       <= 8'h00;
            ins_valid  <= 1'b0;
            ins_opcode <= 8'h00;
            ins_args   <= 16'h0000;
            ins_pc     <= '0;
        end else begin
            ins_valid <= (next_state == S_PRESENT);
            case (state)
                S_LATCH: begin
                    opcode_q <= mem_rdata;
                    argc_q   <= argc_norm;
                    if (argc_norm == 2'd0) begin
                        ins_opcode <= mem_rdata;
                        ins_args   <= 16'h0000;
                        ins_pc     <= pc;
                    end
                end
                S_ARG1: begin
                    b1_q <= mem_rdata;
                    if (argc_q != 2'd2) begin
                        ins_opcode <= opcode_q;
                        ins_args   <= {8'h00, mem_rdata};
                        ins_pc     <= pc;
                    end
                end
                S_ARG2: begin
                    ins_opcode <= opcode_q;
                    ins_args   <= {b1_q, mem_rdata};
                    ins_pc     <= pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the bytecode core. It reads the byte stream from synchronous program memory and drives the current opcode into the combinational opcode decoder. It uses the decoder's argument-byte count to collect 0–2 operand bytes. It then presents the complete instruction (opcode, operands, PC) to the execute stage over a valid/ready handshake, and applies branch/goto redirects on acceptance.

## Interface
Parameters:
- ADDR_WIDTH, 16, program-memory byte-address width; PC width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  out  ADDR_WIDTH  program-memory byte address.
- mem_rd  out  1  read strobe; data returned on mem_rdata exactly one cycle later.
- mem_rdata  in  8  read data.
- dec_opcode  out  8  opcode to decoder.
- dec_argc  in  2  operand-byte count from decoder (combinational on dec_opcode); 2'b11 treated as 2.
- ins_valid  out  1  instruction available.
- ins_ready  in  1  execute stage accepts.
- ins_opcode  out  8  accepted-instruction opcode.
- ins_args  out  16  operands: argc=0 → 0; argc=1 → {8'h00,b1}; argc=2 → {b1,b2} (big-endian).
- ins_pc  out  ADDR_WIDTH  address of the opcode byte.
- jump_en  in  1  redirect; sampled only when ins_valid && ins_ready.
- jump_offset  in  16  signed offset relative to ins_pc.
- halted  out  1  fetch stopped (see Configuration).

## Operation
- States: S_IDLE (reset state), S_OP, S_LATCH, S_ARG1, S_ARG2, S_PRESENT, S_HALT.
- S_IDLE → S_OP unconditionally; mem_rd=0.
- S_OP: mem_rd=1, mem_addr=pc → S_LATCH.
- S_LATCH:
  - dec_opcode=mem_rdata (bypass); opcode_q and argc_q captured.
  - argc=0 → S_PRESENT.
  - Else mem_rd=1, mem_addr=pc+1 → S_ARG1.
- S_ARG1:
  - b1 captured.
  - argc=2: mem_rd=1, mem_addr=pc+2 → S_ARG2.
  - Else → S_PRESENT.
- S_ARG2: b2 captured → S_PRESENT.
- S_PRESENT: ins_valid=1; outputs held stable until handshake. On ins_valid && ins_ready:
  - jump_en=1: pc ← ins_pc + sext/trunc(jump_offset) → S_OP.
  - Else: pc ← pc + 1 + argc_q → S_OP.
- In all states other than S_LATCH, dec_opcode=opcode_q.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_WIDTH; addresses pc+1 and pc+2 wrap.
- jump_en without a handshake is ignored.
- mem_rd=0 in S_IDLE, S_ARG2, S_PRESENT, S_HALT.

## Timing
- Reset values: pc=0, state=S_IDLE, mem_rd=0, mem_addr=0, dec_opcode=8'h00, ins_valid=0, ins_opcode=0, ins_args=0, ins_pc=0, halted=0.
- mem_rd and mem_addr are combinational from state/pc. ins_* outputs are registered.
- Latency, first opcode read to ins_valid: 2 cycles (argc=0), 3 (argc=1), 4 (argc=2). First read occurs one cycle after reset release.
- Throughput: back-to-back argc=0 instructions issue one per 3 cycles with ins_ready held high.
- ins_valid drops the cycle after the handshake and is never asserted outside S_PRESENT.
- Reset mid-fetch: immediate return to reset values; pending memory data is discarded.

## Configuration
- FETCH_HALT_EN defined:
  - When an accepted instruction is IRETURN (0xac), ARETURN (0xb0) or RETURN (0xb1), the FSM enters S_HALT instead of S_OP.
  - In S_HALT: halted=1, mem_rd=0, ins_valid=0.
  - Only reset exits S_HALT.
  - jump_en on a return handshake is ignored.
- FETCH_HALT_EN undefined: S_HALT is not built, halted is tied 0, and return opcodes advance the PC like any other argc=0 instruction.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum.
  - PC_RESET constant (0).
  - Return-opcode constants, reusing the existing opcode definitions.
- One sub-module fetch_pc: PC register plus next-PC mux/adder (sequential +1+argc, or ins_pc+offset), async reset to PC_RESET.

## Test plan
- Memory {0x04, 0x03}, ins_ready=1 → ins_valid 2 cycles after the first mem_rd; ins_opcode=0x04, ins_pc=0, ins_args=0; next instruction has ins_pc=1.
- Memory {0x10 (BIPUSH), 0x7f, 0x00} → ins_args=0x007f; reads at addresses 0 and 1; next ins_pc=2.
- Memory {0x11 (SIPUSH), 0x12, 0x34} with ins_ready low for 5 cycles → ins_args=0x1234 held stable throughout; a single handshake; next ins_pc=3.
- GOTO (0xa7) at address 0x0010, jump_en=1, jump_offset=0xfffc on handshake → next mem_addr=0x000c. Also a PC at 0xffff with argc=1 wraps its operand read to 0x0000.
- RETURN (0xb1) accepted → FETCH_HALT_EN defined: halted=1, no further mem_rd. Undefined: fetch continues at pc+1. rst_n pulse during S_ARG1 → all outputs at reset values, restart at address 0.
